// File: rtl/pending_encoder.sv
// Pending-request encoder: captures one-hot request pulses into a pending set
// and serves them highest-index first through a valid/ready output stage.
module pending_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        E,
  input  logic [15:0] req,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        valid,
  output logic [15:0] pending,
  output logic        overrun
);

  typedef enum logic {StEmpty, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  code_q, code_d;
  logic        overrun_q, overrun_d;

  logic        accept;
  logic        load;
  logic [3:0]  sel;
  logic [15:0] clr_mask;
  logic [15:0] cap_mask;

  // Highest-priority set bit of the registered pending set.
  always_comb begin
    sel = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pending_q[i]) sel = 4'(i);
    end
  end

  // Next-state: load/accept handshake, capture with set-wins-over-clear, overrun.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    accept    = (state_q == StHold) && ready;
    load      = ((state_q == StEmpty) || accept) && (pending_q != 16'd0);
    clr_mask  = load ? (16'd1 << sel) : 16'd0;
    cap_mask  = E ? req : 16'd0;
    pending_d = (pending_q & ~clr_mask) | cap_mask;
    // A request only overruns a bit that stays pending across this edge.
    overrun_d = overrun_q | (|(cap_mask & pending_q & ~clr_mask));

    if (load) begin
      state_d = StHold;
      code_d  = sel;
    end else if (accept) begin
      state_d = StEmpty;
    end
  end

  // State register with synchronous reset taking precedence over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      pending_q <= 16'd0;
      code_q    <= 4'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

  assign code    = code_q;
  assign valid   = (state_q == StHold);
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder: cycle model plus directed scenarios.
module tb_pending_encoder;

  logic        clk;
  logic        rst;
  logic        E;
  logic [15:0] req;
  logic        ready;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;
  logic        overrun;

  int tests;
  int fails;

  pending_encoder dut (
    .clk    (clk),
    .rst    (rst),
    .E      (E),
    .req    (req),
    .ready  (ready),
    .code   (code),
    .valid  (valid),
    .pending(pending),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: abstract view of pending set, held code, valid, sticky flag.
  typedef struct packed {
    logic [15:0] pend;
    logic [3:0]  code;
    logic        valid;
    logic        ovr;
  } mstate_t;

  mstate_t m;
  logic    live;

  function automatic mstate_t mnext(mstate_t s, logic r, logic e, logic rdy,
                                    logic [15:0] rq);
    mstate_t n;
    int      top;
    bit      take;
    if (r) begin
      n = '0;
      return n;
    end
    n   = s;
    top = -1;
    for (int i = 15; i >= 0; i--) begin
      if (s.pend[i] && top < 0) top = i;
    end
    // Stage is free when empty or its code is being taken this cycle.
    take = (!s.valid || rdy) && (top >= 0);
    if (take) begin
      n.pend[top] = 1'b0;
      n.code      = 4'(top);
      n.valid     = 1'b1;
    end else if (s.valid && rdy) begin
      n.valid = 1'b0;
    end
    if (e) begin
      for (int i = 0; i < 16; i++) begin
        if (rq[i]) begin
          if (s.pend[i] && !(take && i == top)) n.ovr = 1'b1;
          n.pend[i] = 1'b1;
        end
      end
    end
    return n;
  endfunction

  initial begin
    m    = '0;
    live = 1'b0;
  end

  always @(posedge clk) begin
    m    <= mnext(m, rst, E, ready, req);
    live <= live | rst;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      chk("model.valid",   {15'd0, valid},   {15'd0, m.valid});
      chk("model.code",    {12'd0, code},    {12'd0, m.code});
      chk("model.pending", pending,          m.pend);
      chk("model.overrun", {15'd0, overrun}, {15'd0, m.ovr});
    end
  end

  // Apply one cycle of inputs; returns just after the closing edge.
  task automatic cyc(input logic [15:0] r, input logic e, input logic rd, input logic rs);
    req   = r;
    E     = e;
    ready = rd;
    rst   = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string name, input logic [3:0] c, input logic v,
                      input logic [15:0] p, input logic o);
    chk({name, ".code"},    {12'd0, code},    {12'd0, c});
    chk({name, ".valid"},   {15'd0, valid},   {15'd0, v});
    chk({name, ".pending"}, pending,          p);
    chk({name, ".overrun"}, {15'd0, overrun}, {15'd0, o});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    req   = 16'hFFFF;
    E     = 1'b1;
    ready = 1'b0;
    rst   = 1'b1;

    // Reset with every request asserted.
    cyc(16'hFFFF, 1'b1, 1'b0, 1'b1);
    cyc(16'hFFFF, 1'b1, 1'b0, 1'b1);
    outs("reset", 4'd0, 1'b0, 16'h0000, 1'b0);

    // Priority drain of 8001 with ready held high.
    cyc(16'h8001, 1'b1, 1'b1, 1'b0);
    outs("drain.n1", 4'd0, 1'b0, 16'h8001, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b0);
    outs("drain.n2", 4'd15, 1'b1, 16'h0001, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b0);
    outs("drain.n3", 4'd0, 1'b1, 16'h0000, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b0);
    outs("drain.n4", 4'd0, 1'b0, 16'h0000, 1'b0);

    // Backpressure: bit 5 held while bit 9 arrives later.
    cyc(16'h0020, 1'b1, 1'b0, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    outs("bp.n2", 4'd5, 1'b1, 16'h0000, 1'b0);
    cyc(16'h0200, 1'b1, 1'b0, 1'b0);
    outs("bp.n4", 4'd5, 1'b1, 16'h0200, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    outs("bp.n6", 4'd5, 1'b1, 16'h0200, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b0);
    outs("bp.n7", 4'd9, 1'b1, 16'h0000, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b0);
    outs("bp.empty", 4'd9, 1'b0, 16'h0000, 1'b0);

    // Set/clear collision on the loading edge: set wins, no overrun.
    cyc(16'h0008, 1'b1, 1'b0, 1'b0);
    cyc(16'h0008, 1'b1, 1'b0, 1'b0);
    outs("collide", 4'd3, 1'b1, 16'h0008, 1'b0);

    // Re-request of the held code is captured, not an overrun.
    cyc(16'h0000, 1'b1, 1'b0, 1'b1);
    cyc(16'h0008, 1'b1, 1'b0, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    outs("held.setup", 4'd3, 1'b1, 16'h0000, 1'b0);
    cyc(16'h0008, 1'b1, 1'b0, 1'b0);
    outs("held.rereq", 4'd3, 1'b1, 16'h0008, 1'b0);

    // Overrun: stage busy with bit 10, bit 3 requested twice.
    cyc(16'h0000, 1'b1, 1'b0, 1'b1);
    cyc(16'h0400, 1'b1, 1'b0, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(16'h0008, 1'b1, 1'b0, 1'b0);
    outs("ovr.n1", 4'd10, 1'b1, 16'h0008, 1'b0);
    cyc(16'h0008, 1'b1, 1'b0, 1'b0);
    outs("ovr.n2", 4'd10, 1'b1, 16'h0008, 1'b1);
    for (int i = 0; i < 10; i++) cyc(16'h0000, 1'b1, (i >= 5), 1'b0);
    chk("ovr.sticky", {15'd0, overrun}, 16'd1);

    // Enable gating: requests ignored, held code still accepted.
    cyc(16'h0000, 1'b1, 1'b0, 1'b1);
    cyc(16'h0040, 1'b1, 1'b0, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(16'hFFFF, 1'b0, 1'b0, 1'b0);
    outs("gate.held", 4'd6, 1'b1, 16'h0000, 1'b0);
    cyc(16'hFFFF, 1'b0, 1'b1, 1'b0);
    outs("gate.accept", 4'd6, 1'b0, 16'h0000, 1'b0);

    // Reset mid-operation with 0F0F pending and a code held.
    cyc(16'h1000, 1'b1, 1'b0, 1'b0);
    cyc(16'h0F0F, 1'b1, 1'b0, 1'b0);
    outs("mid.setup", 4'd12, 1'b1, 16'h0F0F, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b1);
    outs("mid.reset", 4'd0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(16'h0000, 1'b1, 1'b1, 1'b0);
    outs("mid.quiet", 4'd0, 1'b0, 16'h0000, 1'b0);

    // First edge after reset captures normally.
    cyc(16'h0101, 1'b1, 1'b1, 1'b0);
    outs("post.capture", 4'd0, 1'b0, 16'h0101, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b0);
    outs("post.load", 4'd8, 1'b1, 16'h0001, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b0);
    cyc(16'h0000, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
